// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and width helpers for the UART transmit arbiter and its picker.
package uart_arb_pkg;

    // Byte sequencing state encodings.
    localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
    localparam logic [1:0] ST_START_ENC     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY_ENC = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_START     = ST_START_ENC,
        ST_WAIT_BUSY = ST_WAIT_BUSY_ENC,
        ST_WAIT_DONE = ST_WAIT_DONE_ENC
    } arb_state_t;

    // Largest requester count the arbiter is built for, and its index width.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = $clog2(MAX_REQ);

    // Index width for n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake and uart_tx-side byte port, bundled for the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;

    // Environment side: the byte producers plus the uart_tx busy flag.
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Scan from ptr+1 around to ptr itself; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers with round-robin grant and a
// packet lock, sequencing each byte through start, busy-rise and busy-fall.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16,
    parameter int LOCK_TIMEOUT = 1_000_000,
    parameter int IW           = idx_w(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus,
    output logic [IW-1:0]     grant_id,
    output logic              locked,
    output logic              err_busy_to,
    output logic              err_lock_to
);

    localparam int BW = $clog2(BUSY_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t          state;
    logic [IW-1:0]       rr_ptr;
    logic [BW-1:0]       busy_cnt;
    logic [LW-1:0]       lock_cnt;

    logic [NUM_REQ-1:0]  owner_mask;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic [7:0]          pick_byte;
    logic                pick_last;
    logic                owner_valid;
    logic                accept;

    // While locked only the lock owner may compete; otherwise every valid requester does.
    always_comb begin
        owner_mask  = NUM_REQ'(1) << grant_id;
        owner_valid = |(bus.req_valid & owner_mask);
        eligible    = locked ? (bus.req_valid & owner_mask) : bus.req_valid;
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Select the winning byte and its last flag from the one-hot grant.
    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_byte = bus.req_data[8*i +: 8];
        end
        pick_last = |(pick_oh & bus.req_last);
    end

    // Accept only in IDLE with the transmitter quiet; ready is held low during reset.
    always_comb begin
        accept        = !rst && (state == ST_IDLE) && !bus.tx_busy && pick_any;
        bus.req_ready = accept ? pick_oh : '0;
    end

    // Byte sequencer with lock and busy timeouts; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
            grant_id     <= '0;
            locked       <= 1'b0;
            err_busy_to  <= 1'b0;
            err_lock_to  <= 1'b0;
            rr_ptr       <= IW'(NUM_REQ - 1);
            busy_cnt     <= '0;
            lock_cnt     <= '0;
        end else begin
            bus.tx_start <= 1'b0;
            err_busy_to  <= 1'b0;
            err_lock_to  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.tx_data  <= pick_byte;
                        grant_id     <= pick_idx;
                        rr_ptr       <= pick_idx;
                        locked       <= !pick_last;
                        lock_cnt     <= '0;
                        bus.tx_start <= 1'b1;
                        state        <= ST_START;
                    end else if (locked && !owner_valid) begin
                        // A byte from the owner in the expiry cycle is accepted above instead.
                        if (lock_cnt >= LW'(LOCK_TIMEOUT - 1)) begin
                            err_lock_to <= 1'b1;
                            locked      <= 1'b0;
                            lock_cnt    <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LW'(1);
                        end
                    end
                end
                ST_START: begin
                    // The start cycle counts as the first cycle of the busy wait.
                    busy_cnt <= BW'(1);
                    state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (busy_cnt >= BW'(BUSY_TIMEOUT - 1)) begin
                        err_busy_to <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + BW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
